// File: rtl/gcd_engine.sv
// GCD engine: subtractive Euclid or binary Stein, chosen at elaboration.
// One operation in flight; valid/ready on both sides, saturating cycle count.
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int ALGO  = 0,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               io_in_valid,
   input  logic [2*WIDTH-1:0] io_in_data,
   output logic               io_in_ready,
   output logic               io_out_valid,
   input  logic               io_out_ready,
   output logic [WIDTH-1:0]   io_out_data,
   output logic [CNT_W-1:0]   io_out_cycles
);

   localparam int KW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
   logic [KW-1:0]      k;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic [2*WIDTH-1:0] x_sh;
   logic [2*WIDTH-1:0] y_sh;

   assign io_in_ready  = (state == IDLE);
   assign io_out_valid = (state == DONE);

   // Saturating next count and the Stein result shifts, done at double width.
   always_comb begin
      cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
      x_sh    = {{WIDTH{1'b0}}, x} << k;
      y_sh    = {{WIDTH{1'b0}}, y} << k;
   end

   // Control FSM and datapath: one reduction step per BUSY cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         x             <= '0;
         y             <= '0;
         k             <= '0;
         cnt           <= '0;
         io_out_data   <= '0;
         io_out_cycles <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (io_in_valid) begin
                  x     <= io_in_data[WIDTH-1:0];
                  y     <= io_in_data[2*WIDTH-1:WIDTH];
                  k     <= '0;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt_inc;
               if (ALGO == 0) begin
                  if (y == '0) begin
                     io_out_data   <= x;
                     io_out_cycles <= cnt_inc;
                     state         <= DONE;
                  end else if (x == '0) begin
                     io_out_data   <= y;
                     io_out_cycles <= cnt_inc;
                     state         <= DONE;
                  end else if (x > y) begin
                     x <= y;
                     y <= x;
                  end else begin
                     y <= y - x;
                  end
               end else begin
                  if (x == '0) begin
                     io_out_data   <= y_sh[WIDTH-1:0];
                     io_out_cycles <= cnt_inc;
                     state         <= DONE;
                  end else if (y == '0) begin
                     io_out_data   <= x_sh[WIDTH-1:0];
                     io_out_cycles <= cnt_inc;
                     state         <= DONE;
                  end else if (!x[0] && !y[0]) begin
                     x <= x >> 1;
                     y <= y >> 1;
                     k <= k + KW'(1);
                  end else if (!x[0]) begin
                     x <= x >> 1;
                  end else if (!y[0]) begin
                     y <= y >> 1;
                  end else if (x >= y) begin
                     x <= (x - y) >> 1;
                  end else begin
                     y <= (y - x) >> 1;
                  end
               end
            end
            DONE: begin
               if (io_out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: Euclid, Stein and a narrow-counter Euclid
// instance, covering zero operands, backpressure, saturation and reset.
module tb_gcd_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid [3];
   logic [31:0] in_data  [3];
   logic        in_ready [3];
   logic        out_valid[3];
   logic        out_ready[3];
   logic [15:0] out_data [3];
   logic [15:0] cyc0;
   logic [15:0] cyc1;
   logic [7:0]  cyc2;

   int pass  = 0;
   int total = 0;

   always #5 clk = ~clk;

   gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_W(16)) u_euclid (
      .clk(clk), .reset(reset),
      .io_in_valid(in_valid[0]), .io_in_data(in_data[0]),
      .io_in_ready(in_ready[0]), .io_out_valid(out_valid[0]),
      .io_out_ready(out_ready[0]), .io_out_data(out_data[0]),
      .io_out_cycles(cyc0)
   );

   gcd_engine #(.WIDTH(16), .ALGO(1), .CNT_W(16)) u_stein (
      .clk(clk), .reset(reset),
      .io_in_valid(in_valid[1]), .io_in_data(in_data[1]),
      .io_in_ready(in_ready[1]), .io_out_valid(out_valid[1]),
      .io_out_ready(out_ready[1]), .io_out_data(out_data[1]),
      .io_out_cycles(cyc1)
   );

   gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_W(8)) u_sat (
      .clk(clk), .reset(reset),
      .io_in_valid(in_valid[2]), .io_in_data(in_data[2]),
      .io_in_ready(in_ready[2]), .io_out_valid(out_valid[2]),
      .io_out_ready(out_ready[2]), .io_out_data(out_data[2]),
      .io_out_cycles(cyc2)
   );

   function automatic logic [15:0] get_cyc(input int d);
      case (d)
         0:       return cyc0;
         1:       return cyc1;
         default: return {8'h00, cyc2};
      endcase
   endfunction

   // Launch one operation and wait (bounded) for io_out_valid.
   // n = number of BUSY cycles observed before the result appeared.
   task automatic run_op(input int d, input logic [15:0] a,
                         input logic [15:0] b, input int budget,
                         output logic [15:0] res,
                         output logic [15:0] c, output int n);
      n = 0;
      @(negedge clk);
      in_data[d]  = {b, a};
      in_valid[d] = 1'b1;
      @(negedge clk);
      in_valid[d] = 1'b0;
      while (out_valid[d] !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (out_valid[d] !== 1'b1) begin
         $display("FAIL timeout dut%0d a=%0d b=%0d: no io_out_valid in %0d cycles",
                  d, a, b, budget);
      end else begin
         pass++;
      end
      res = out_data[d];
      c   = get_cyc(d);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b1;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         total++;
         if (in_ready[d] !== 1'b1)
            $display("FAIL reset_in_ready dut%0d got %b want 1", d, in_ready[d]);
         else pass++;
         total++;
         if (out_valid[d] !== 1'b0)
            $display("FAIL reset_out_valid dut%0d got %b want 0", d, out_valid[d]);
         else pass++;
         total++;
         if (out_data[d] !== 16'd0)
            $display("FAIL reset_out_data dut%0d got %0d want 0", d, out_data[d]);
         else pass++;
         total++;
         if (get_cyc(d) !== 16'd0)
            $display("FAIL reset_cycles dut%0d got %0d want 0", d, get_cyc(d));
         else pass++;
      end
   endtask

   task automatic test_euclid();
      logic [15:0] r, c;
      int n;
      run_op(0, 16'd12, 16'd18, 100, r, c, n);
      total++;
      if (r !== 16'd6) $display("FAIL euclid_12_18_data got %0d want 6", r);
      else pass++;
      total++;
      if (c !== 16'd5) $display("FAIL euclid_12_18_cycles got %0d want 5", c);
      else pass++;
      total++;
      if (n !== 5) $display("FAIL euclid_12_18_latency got %0d want 5", n);
      else pass++;
      total++;
      if (in_ready[0] !== 1'b0)
         $display("FAIL euclid_ready_in_done got %b want 0", in_ready[0]);
      else pass++;
      @(negedge clk);
      total++;
      if (in_ready[0] !== 1'b1)
         $display("FAIL euclid_ready_after_hs got %b want 1", in_ready[0]);
      else pass++;
      total++;
      if (out_valid[0] !== 1'b0)
         $display("FAIL euclid_valid_after_hs got %b want 0", out_valid[0]);
      else pass++;
   endtask

   task automatic test_stein();
      logic [15:0] r, c;
      int n;
      run_op(1, 16'd12, 16'd18, 100, r, c, n);
      total++;
      if (r !== 16'd6) $display("FAIL stein_12_18_data got %0d want 6", r);
      else pass++;
      total++;
      if (c !== 16'd5) $display("FAIL stein_12_18_cycles got %0d want 5", c);
      else pass++;
      total++;
      if (n !== 5) $display("FAIL stein_12_18_latency got %0d want 5", n);
      else pass++;
      run_op(1, 16'd48, 16'd180, 100, r, c, n);
      total++;
      if (r !== 16'd12) $display("FAIL stein_48_180_data got %0d want 12", r);
      else pass++;
      total++;
      if (c !== 16'd9) $display("FAIL stein_48_180_cycles got %0d want 9", c);
      else pass++;
   endtask

   task automatic test_zero();
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic [15:0] ve [3];
      logic [15:0] r, c;
      int n;
      va = '{16'd0, 16'd0, 16'd7};
      vb = '{16'd0, 16'd5, 16'd0};
      ve = '{16'd0, 16'd5, 16'd7};
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 3; i++) begin
            run_op(d, va[i], vb[i], 20, r, c, n);
            total++;
            if (r !== ve[i])
               $display("FAIL zero_data dut%0d (%0d,%0d) got %0d want %0d",
                        d, va[i], vb[i], r, ve[i]);
            else pass++;
            total++;
            if (c !== 16'd1)
               $display("FAIL zero_cycles dut%0d (%0d,%0d) got %0d want 1",
                        d, va[i], vb[i], c);
            else pass++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [15:0] r, c;
      int n;
      out_ready[0] = 1'b0;
      run_op(0, 16'd12, 16'd18, 100, r, c, n);
      for (int i = 0; i < 10; i++) begin
         in_data[0]  = {16'd75, 16'd100};
         in_valid[0] = (i % 2 == 0);
         @(negedge clk);
         total++;
         if (out_valid[0] !== 1'b1)
            $display("FAIL bp_valid cyc%0d got %b want 1", i, out_valid[0]);
         else pass++;
         total++;
         if (out_data[0] !== 16'd6)
            $display("FAIL bp_data cyc%0d got %0d want 6", i, out_data[0]);
         else pass++;
         total++;
         if (cyc0 !== 16'd5)
            $display("FAIL bp_cycles cyc%0d got %0d want 5", i, cyc0);
         else pass++;
         total++;
         if (in_ready[0] !== 1'b0)
            $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready[0]);
         else pass++;
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid[0] !== 1'b0)
         $display("FAIL bp_release_valid got %b want 0", out_valid[0]);
      else pass++;
      total++;
      if (in_ready[0] !== 1'b1)
         $display("FAIL bp_release_ready got %b want 1", in_ready[0]);
      else pass++;
      run_op(0, 16'd9, 16'd6, 100, r, c, n);
      total++;
      if (r !== 16'd3) $display("FAIL bp_next_op got %0d want 3", r);
      else pass++;
      total++;
      if (c !== 16'd6) $display("FAIL bp_next_cycles got %0d want 6", c);
      else pass++;
      @(negedge clk);
   endtask

   task automatic test_saturation();
      logic [15:0] r, c;
      int n;
      run_op(2, 16'd1, 16'd65535, 70000, r, c, n);
      total++;
      if (r !== 16'd1) $display("FAIL sat_data got %0d want 1", r);
      else pass++;
      total++;
      if (c !== 16'd255) $display("FAIL sat_cycles got %0d want 255", c);
      else pass++;
      total++;
      if (n !== 65536) $display("FAIL sat_latency got %0d want 65536", n);
      else pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_busy();
      logic [15:0] r, c;
      int n;
      @(negedge clk);
      in_data[0]  = {16'd65535, 16'd1};
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (19) @(negedge clk);
      total++;
      if (in_ready[0] !== 1'b0)
         $display("FAIL mid_busy_ready got %b want 0", in_ready[0]);
      else pass++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (in_ready[0] !== 1'b1)
         $display("FAIL mid_reset_ready got %b want 1", in_ready[0]);
      else pass++;
      total++;
      if (out_valid[0] !== 1'b0)
         $display("FAIL mid_reset_valid got %b want 0", out_valid[0]);
      else pass++;
      total++;
      if (out_data[0] !== 16'd0)
         $display("FAIL mid_reset_data got %0d want 0", out_data[0]);
      else pass++;
      total++;
      if (cyc0 !== 16'd0)
         $display("FAIL mid_reset_cycles got %0d want 0", cyc0);
      else pass++;
      run_op(0, 16'd9, 16'd6, 100, r, c, n);
      total++;
      if (r !== 16'd3) $display("FAIL after_reset_gcd got %0d want 3", r);
      else pass++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_euclid();
      test_stein();
      test_zero();
      test_backpressure();
      test_saturation();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
